stmt_lowerer_seq_encoder: RTL
=============================

# stmt_lowerer_seq_encoder

Sequential one-hot/priority encoder fixture for the convert flow. It is the encode-side counterpart to the combinational case/casez/case-inside selector fixtures. It accepts a request bit-vector over a valid/ready handshake and emits the index of each set bit, lowest first, one per output handshake. Each emitted index carries a range class code, and the block keeps a saturating count of bits dropped by the burst limit. It exercises `always_ff` lowering of casez priority decode, case-inside range classification, for-loop popcount and an explicit FSM.

## Interface
- `BURST_MAX`, default 4: maximum indices emitted per accepted vector; legal range 1..8.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_req`  in  8  request vector; bit i set means index i is requested.
- `out_valid`  out  1  encoded index valid.
- `out_ready`  in  1  consumer accepts the index.
- `out_idx`  out  3  index of the lowest pending set bit.
- `out_cls`  out  2  range class of `out_idx`.
- `out_last`  out  1  this index is the final one emitted for the current vector.
- `drop_cnt`  out  8  saturating count of set bits discarded by the burst limit.

## Operation
- Registers:
  - `state` is IDLE or EMIT.
  - `pending` is 8 bits.
  - `emitted` is 4 bits.
  - `drop_cnt` is 8 bits.
- `in_ready` = (state == IDLE). It is combinational.
- `out_valid` = (state == EMIT). It is combinational.
- IDLE, on `in_valid && in_ready`:
  - `in_req == 0`: the vector is consumed and discarded; the block stays in IDLE and produces no output.
  - Otherwise: `pending <= in_req`, `emitted <= 0`, `state <= EMIT`.
- EMIT outputs, all derived combinationally from registers:
  - `out_idx` is the lowest set bit of `pending`, found by a casez priority decode.
  - `out_cls` comes from a case-inside decode on `out_idx`: 0 gives 0; [1:3] gives 1; [4:5] gives 2; default (6, 7) gives 3.
  - `out_last` = (popcount(`pending`) == 1) || (`emitted` == BURST_MAX-1).
  - popcount is computed by a for loop over 8 bits.
- EMIT, on `out_valid && out_ready`:
  - The bit at `out_idx` is cleared in `pending`, and `emitted` increments.
  - If `out_last` is set: `drop_cnt <= min(255, drop_cnt + popcount(pending) - 1)`, `pending <= 0`, `state <= IDLE`.
- In EMIT without `out_ready`, all registers hold.
- Arithmetic: do the `drop_cnt` sum at 9 bits, then clamp it to 255. `drop_cnt` never wraps.
- `in_valid` is ignored while in EMIT; nothing is queued.
- Reset (asynchronous, any time, including mid-EMIT):
  - `state` = IDLE; `pending`, `emitted` and `drop_cnt` = 0.
  - During and after reset, outputs are: `out_valid` = 0, `out_idx` = 0, `out_cls` = 0, `out_last` = 0, `in_ready` = 1, `drop_cnt` = 0.
  - Any in-flight vector is lost and is not counted as dropped.

## Timing
- Vector accepted at edge N: `out_valid` = 1 in the cycle after N, with the first index.
- With `out_ready` held high, one index per cycle. The final handshake at edge M returns the block to IDLE, and `in_ready` = 1 in the cycle after M.
- Per-vector occupancy is min(popcount, BURST_MAX) + 1 cycles, including the acceptance cycle.
- `out_idx`, `out_cls` and `out_last` must stay stable while `out_valid && !out_ready`.
- `drop_cnt` updates at the final handshake edge and is visible in the next cycle.
- No combinational path from `in_*` to `out_*`. `in_ready` does not depend on `in_valid`.

## Test plan
- Reset mid-EMIT:
  - Stimulus: vector 8'hFF accepted, two indices emitted, then `rst_n` pulsed low.
  - Required: `out_valid` = 0, `out_idx` = 0, `out_cls` = 0, `out_last` = 0, `in_ready` = 1 and `drop_cnt` = 0 immediately, without waiting for a clock edge.
- Sparse vector:
  - Stimulus: `in_req` = 8'b1010_0100, BURST_MAX = 4, `out_ready` = 1.
  - Required: (idx 2, cls 1), (idx 5, cls 2), (idx 7, cls 3, last) on three consecutive cycles; `drop_cnt` stays 0; `in_ready` = 1 in the following cycle.
- Burst limit:
  - Stimulus: `in_req` = 8'hFF, BURST_MAX = 4.
  - Required: idx 0, 1, 2, 3 with cls 0, 1, 1, 1; `out_last` on idx 3; `drop_cnt` = 4 afterwards.
- Backpressure:
  - Stimulus: `in_req` = 8'h30 with `out_ready` low for 3 cycles, then high.
  - Required: `out_valid` = 1, idx 4, cls 2, last 0 held stable for all 3 stalled cycles; then idx 5, cls 2, last 1.
- Zero vector:
  - Stimulus: `in_req` = 0 with `in_valid` = 1 for 2 cycles.
  - Required: `out_valid` stays 0, `in_ready` stays 1, `drop_cnt` unchanged.
- Saturation:
  - Stimulus: 64 vectors of 8'hFF, BURST_MAX = 4 (256 dropped bits).
  - Required: `drop_cnt` = 252 after 63 vectors and 255 after 64; a 65th 8'hFF vector leaves it at 255.

Source files
------------

// File: rtl/stmt_lowerer_seq_encoder.sv
// Sequential priority encoder: accepts an 8-bit request vector and emits the index
// of each set bit, lowest first, capped at BURST_MAX indices per vector.
module stmt_lowerer_seq_encoder #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic [1:0] out_cls,
    output logic       out_last,
    output logic [7:0] drop_cnt
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state_reg, state_next;
    logic [7:0] pending_reg, pending_next;
    logic [3:0] emitted_reg, emitted_next;
    logic [7:0] drop_cnt_reg, drop_cnt_next;

    logic [2:0] low_idx;
    logic [1:0] low_cls;
    logic [3:0] pop;
    logic [7:0] clear_mask;
    logic [8:0] drop_sum;
    logic       last_raw;

    always_comb begin
        low_idx = 3'd0;
        casez (pending_reg)
            8'b???????1: low_idx = 3'd0;
            8'b??????10: low_idx = 3'd1;
            8'b?????100: low_idx = 3'd2;
            8'b????1000: low_idx = 3'd3;
            8'b???10000: low_idx = 3'd4;
            8'b??100000: low_idx = 3'd5;
            8'b?1000000: low_idx = 3'd6;
            8'b10000000: low_idx = 3'd7;
            default:     low_idx = 3'd0;
        endcase
    end

    always_comb begin
        low_cls = 2'd3;
        case (low_idx) inside
            3'd0:         low_cls = 2'd0;
            [3'd1:3'd3]:  low_cls = 2'd1;
            [3'd4:3'd5]:  low_cls = 2'd2;
            default:      low_cls = 2'd3;
        endcase
    end

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, pending_reg[i]};
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_clear
            assign clear_mask[gi] = (low_idx == 3'(gi));
        end
    endgenerate

    // Only evaluated on the final handshake, where pop >= 1, so the -1 cannot underflow.
    assign drop_sum = {1'b0, drop_cnt_reg} + {5'd0, pop} - 9'd1;
    assign last_raw = (pop == 4'd1) || (emitted_reg == 4'(BURST_MAX - 1));

    // Index outputs are forced to zero outside EMIT so idle/reset presents clean zeros.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == EMIT);
    assign out_idx   = out_valid ? low_idx : 3'd0;
    assign out_cls   = out_valid ? low_cls : 2'd0;
    assign out_last  = out_valid && last_raw;
    assign drop_cnt  = drop_cnt_reg;

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        emitted_next  = emitted_reg;
        drop_cnt_next = drop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_req != 8'd0) begin
                    pending_next = in_req;
                    emitted_next = 4'd0;
                    state_next   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~clear_mask;
                    emitted_next = emitted_reg + 4'd1;
                    if (last_raw) begin
                        drop_cnt_next = drop_sum[8] ? 8'd255 : drop_sum[7:0];
                        pending_next  = 8'd0;
                        state_next    = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pending_reg  <= 8'd0;
            emitted_reg  <= 4'd0;
            drop_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            emitted_reg  <= emitted_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

endmodule
